ps2_rx_framed: RTL
==================

# ps2_rx_framed

Parametrised PS/2 receive path that replaces the fixed 8-bit data-in receiver in the PS/2 core. It deserialises device-to-host frames sampled on `ps2_clk_posedge` strobes from the clock-edge detector. It also checks odd parity and the stop bit, and aborts frames whose PS/2 clock stalls. Good bytes are buffered in a small FIFO with a valid/ready output, so the consumer no longer has to catch a one-cycle enable pulse.

## Interface
- `DATA_BITS`, 8 — payload bits per frame, LSB first; valid range 5..9.
- `PARITY_EN`, 1 — 1: a parity bit follows the data and is checked for odd parity; 0: no parity bit in the frame.
- `TIMEOUT_CYCLES`, 50000 — maximum `clk` cycles between consecutive `ps2_clk_posedge` strobes inside a frame; must be at least 2.
- `FIFO_DEPTH`, 4 — number of received words buffered; must be at least 1.
- `clk` in 1 — system clock.
- `reset` in 1 — reset, synchronous, active-high; clock `clk`.
- `wait_for_incoming_data` in 1 — level; arm the receiver to hunt for a start bit.
- `start_receiving_data` in 1 — level; the start bit has already been consumed (after a host command), so go straight to data bits.
- `ps2_clk_posedge` in 1 — one-`clk` strobe marking a PS/2 clock rising edge; `ps2_data` is sampled only on this strobe.
- `ps2_data` in 1 — synchronised PS/2 data line.
- `rx_ready` in 1 — consumer accepts `rx_data` this cycle.
- `rx_data` out DATA_BITS — FIFO head word.
- `rx_valid` out 1 — FIFO not empty.
- `rx_count` out clog2(FIFO_DEPTH+1) — FIFO occupancy.
- `parity_err` out 1 — one-cycle pulse: frame dropped because of bad parity.
- `frame_err` out 1 — one-cycle pulse: frame dropped because the stop bit was 0.
- `timeout_err` out 1 — one-cycle pulse: frame aborted because the PS/2 clock stalled.
- `overflow` out 1 — one-cycle pulse: a good frame was dropped because the FIFO was full.

## Operation
- States: IDLE, WAIT_START, DATA, PARITY, STOP.
- IDLE:
  - `wait_for_incoming_data`=1 → WAIT_START. This input has priority.
  - Otherwise `start_receiving_data`=1 → DATA.
  - FIFO occupancy does not gate either transition.
- WAIT_START:
  - Strobe with `ps2_data`=0 → DATA.
  - Otherwise `wait_for_incoming_data`=0 → IDLE.
  - A strobe with `ps2_data`=1 is ignored.
- DATA:
  - Each strobe shifts `{ps2_data, sr[DATA_BITS-1:1]}` and increments the bit counter.
  - On the strobe that captures bit DATA_BITS-1: go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: the strobe latches the parity bit → STOP.
- STOP, on its strobe:
  - Parity is good when the XOR of the data bits and the parity bit is 1. It is always good when `PARITY_EN`=0.
  - Good parity and `ps2_data`=1 → push the word; if the FIFO is full and no pop happens this cycle, drop the word and pulse `overflow`.
  - Bad parity → pulse `parity_err`.
  - `ps2_data`=0 → pulse `frame_err`.
  - Both errors can pulse in the same cycle. An errored frame is never pushed.
  - Next state is IDLE.
- Timeout:
  - The stall counter clears on every strobe and on entry to DATA.
  - It increments every `clk` while in DATA, PARITY or STOP.
  - On reaching TIMEOUT_CYCLES-1 without a strobe: pulse `timeout_err`, discard the partial frame, go to IDLE.
  - If a strobe arrives in that same cycle, the strobe wins and no timeout occurs.
- The bit counter and shift register clear whenever the state is not DATA/PARITY/STOP.
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH, which need not be a power of two.
  - Pop when `rx_valid && rx_ready`.
  - Simultaneous push and pop: both take effect and `rx_count` is unchanged. This also applies when full, where the push is accepted and `overflow` does not pulse.
  - `rx_ready` while empty has no effect.

## Timing
- Reset values:
  - state IDLE.
  - `rx_valid`=0, `rx_count`=0, `rx_data`=0, all error pulses 0.
  - FIFO, pointers, shift register and counters cleared.
- Reset mid-frame or with a non-empty FIFO discards everything.
- All outputs are registered.
- Push latency: a word pushed at the `clk` edge where STOP sees a strobe gives `rx_valid`=1 and `rx_data` equal to that word from the next cycle, if the FIFO was empty.
- `rx_data` is stable while `rx_valid`=1 and `rx_ready`=0. After a pop, the next word appears on the following cycle.
- Error and overflow pulses are asserted in the cycle after the deciding strobe or the timeout, for exactly one cycle.

## Test plan
- Defaults (8 bits, parity on), `wait_for_incoming_data`=1, frame start 0, data 0xA5 LSB first, parity 1, stop 1 → `rx_valid` one cycle after the stop strobe, `rx_data`=0xA5, `rx_count`=1, no error pulses; `rx_ready`=1 → `rx_count`=0.
- Frame 0x1C with parity 1 (even total) → `parity_err` pulses once, `rx_valid` stays 0. Then 0x1C with parity 0 and stop 0 → `frame_err` only.
- `start_receiving_data`=1, three data strobes, then no strobe for 50000 cycles → `timeout_err` pulses once, state back to IDLE. A following good 0x55 frame (parity 1) is received correctly.
- `rx_ready`=0, five good frames 0x01..0x05 (parity 0,0,1,0,1) → `rx_count`=4, `overflow` pulses on the 5th. Draining yields 0x01..0x04 in order.
- FIFO full with `rx_ready`=1 held on the cycle a 0x06 frame (parity 1) completes → no `overflow`, `rx_count` stays 4, 0x06 read last.
- `DATA_BITS`=7, `PARITY_EN`=0, frame 0x7F → `rx_data`=0x7F; assert `reset` mid-frame → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/ps2_rx_framed_if.sv
// Valid/ready stream carrying received PS/2 words from the receiver FIFO to its consumer.
interface ps2_rx_framed_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_rx_framed.sv
// PS/2 device-to-host frame receiver: deserialiser with parity/stop/stall checks
// feeding a small circular FIFO with a registered valid/ready head.
module ps2_rx_framed #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 1,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wait_for_incoming_data,
    input  logic                              start_receiving_data,
    input  logic                              ps2_clk_posedge,
    input  logic                              ps2_data,
    ps2_rx_framed_if.master                   rx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              timeout_err,
    output logic                              overflow
);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, PARITY, STOP} state_t;

    state_t               state_reg, state_next;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] sr_reg;
    logic                 parity_bit_reg;
    logic [TO_W-1:0]      stall_reg;

    logic [DATA_BITS-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DATA_BITS-1:0] rx_data_reg, head_next;
    logic                 rx_valid_reg;
    logic [FIFO_DEPTH-1:0] wr_sel;

    logic active, timeout, frame_done, parity_good, word_good, pop, full, push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign active  = (state_reg == DATA) || (state_reg == PARITY) || (state_reg == STOP);
    // A strobe in the deciding cycle always beats the stall limit.
    assign timeout = active && !ps2_clk_posedge && (stall_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wait_for_incoming_data)    state_next = WAIT_START;
                else if (start_receiving_data) state_next = DATA;
            end
            WAIT_START: begin
                if (ps2_clk_posedge && !ps2_data) state_next = DATA;
                else if (!wait_for_incoming_data) state_next = IDLE;
            end
            DATA: begin
                if (ps2_clk_posedge && bit_cnt_reg == BIT_W'(DATA_BITS - 1))
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (ps2_clk_posedge) state_next = STOP;
            end
            STOP: begin
                if (ps2_clk_posedge) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = IDLE;
    end

    always_comb begin
        parity_good = (PARITY_EN == 0) ? 1'b1 : (^sr_reg ^ parity_bit_reg);
        word_good   = frame_done && parity_good && ps2_data;
        pop         = rx_valid_reg && rx.rx_ready;
        full        = (count_reg == CNT_W'(FIFO_DEPTH));
        // When full, a same-cycle pop frees the slot the push needs.
        push_ok     = word_good && (!full || pop);
        rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok && !pop)      count_next = count_reg + 1'b1;
        else if (!push_ok && pop) count_next = count_reg - 1'b1;
        head_next = rx_data_reg;
        if (count_next != '0)
            head_next = (push_ok && wr_ptr_reg == rd_ptr_next) ? sr_reg : mem_reg[rd_ptr_next];
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            sr_reg         <= '0;
            parity_bit_reg <= 1'b0;
            stall_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
            timeout_err    <= 1'b0;
            overflow       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (!active) begin
                bit_cnt_reg    <= '0;
                sr_reg         <= '0;
                parity_bit_reg <= 1'b0;
                stall_reg      <= '0;
            end else begin
                stall_reg <= (ps2_clk_posedge || timeout) ? '0 : stall_reg + 1'b1;
                if (state_reg == DATA && ps2_clk_posedge) begin
                    sr_reg      <= {ps2_data, sr_reg[DATA_BITS-1:1]};
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                if (state_reg == PARITY && ps2_clk_posedge) parity_bit_reg <= ps2_data;
            end
            parity_err  <= frame_done && !parity_good;
            frame_err   <= frame_done && !ps2_data;
            timeout_err <= timeout;
            overflow    <= word_good && full && !pop;
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (wr_sel[i]) mem_reg[i] <= sr_reg;
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rx_valid_reg <= (count_next != '0);
            rx_data_reg  <= head_next;
        end
    end

    assign rx.rx_data  = rx_data_reg;
    assign rx.rx_valid = rx_valid_reg;
    assign rx_count    = count_reg;
endmodule
